// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and flag payload.
package alu_seq_pkg;

   localparam int unsigned OPW = 4;

   localparam logic [OPW-1:0] OP_AND   = 4'd0;
   localparam logic [OPW-1:0] OP_OR    = 4'd1;
   localparam logic [OPW-1:0] OP_ADD   = 4'd2;
   localparam logic [OPW-1:0] OP_SLL   = 4'd3;
   localparam logic [OPW-1:0] OP_XOR   = 4'd4;
   localparam logic [OPW-1:0] OP_SRA   = 4'd5;
   localparam logic [OPW-1:0] OP_SUB   = 4'd6;
   localparam logic [OPW-1:0] OP_SLTU  = 4'd7;
   localparam logic [OPW-1:0] OP_SLT   = 4'd8;
   localparam logic [OPW-1:0] OP_SRL   = 4'd9;
   localparam logic [OPW-1:0] OP_SLLI  = 4'd10;
   localparam logic [OPW-1:0] OP_SRLI  = 4'd11;
   localparam logic [OPW-1:0] OP_NOR   = 4'd12;
   localparam logic [OPW-1:0] OP_SRAI  = 4'd13;
   localparam logic [OPW-1:0] OP_MULLO = 4'd14;
   localparam logic [OPW-1:0] OP_DIVU  = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      HOLD = 2'd2
   } state_e;

   typedef struct packed {
      logic carry;
      logic zero;
      logic negative;
      logic overflow;
   } alu_flags_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Bit-serial datapath: shift-add multiply (low half) and restoring unsigned divide.
module alu_seq_iter
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done_c,
   output logic [WIDTH-1:0] result_c
);

   localparam int unsigned SHW = $clog2(WIDTH);

   logic             run;
   logic             div_q;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] acc;    // product accumulator / partial remainder
   logic [WIDTH-1:0] sh;     // multiplier / dividend shifting into quotient
   logic [WIDTH-1:0] mc;     // multiplicand / divisor
   logic [WIDTH-1:0] acc_nx;
   logic [WIDTH-1:0] sh_nx;
   logic [WIDTH-1:0] mc_nx;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;

   // One iteration step; bit WIDTH of diff set means the trial subtract went negative.
   always_comb begin
      rem_sh = {acc, sh[WIDTH-1]};
      diff   = rem_sh - {1'b0, mc};
      acc_nx = acc;
      sh_nx  = sh;
      mc_nx  = mc;
      if (div_q) begin
         if (!diff[WIDTH]) begin
            acc_nx = diff[WIDTH-1:0];
            sh_nx  = {sh[WIDTH-2:0], 1'b1};
         end else begin
            acc_nx = rem_sh[WIDTH-1:0];
            sh_nx  = {sh[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nx = sh[0] ? acc + mc : acc;
         sh_nx  = sh >> 1;
         mc_nx  = mc << 1;
      end
   end

   // The final step's value is handed out directly so the result lands on the same edge.
   assign done_c   = run && (cnt == SHW'(WIDTH - 1));
   assign result_c = div_q ? sh_nx : acc_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run   <= 1'b0;
         div_q <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
         sh    <= '0;
         mc    <= '0;
      end else if (start) begin
         run   <= 1'b1;
         div_q <= (op == OP_DIVU);
         cnt   <= '0;
         acc   <= '0;
         sh    <= (op == OP_DIVU) ? a : b;
         mc    <= (op == OP_DIVU) ? b : a;
      end else if (run) begin
         acc <= acc_nx;
         sh  <= sh_nx;
         mc  <= mc_nx;
         cnt <= cnt + SHW'(1);
         if (done_c) begin
            run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes; single-cycle ops plus iterative MULLO/DIVU.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_negative,
   output logic             out_overflow,
   output logic             busy
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned W1  = WIDTH + 1;

   state_e           state;
   state_e           state_d;
   logic             accept_c;
   logic             start_c;
   logic             load_single_c;
   logic             load_iter_c;
   logic             iter_done_c;
   logic [WIDTH-1:0] iter_result_c;
   logic [WIDTH-1:0] res_c;
   logic [WIDTH:0]   sum_c;
   logic [SHW-1:0]   shamt_c;
   alu_flags_t       flags_c;
   alu_flags_t       iter_flags_c;
   logic [WIDTH-1:0] result_q;
   alu_flags_t       flags_q;

   assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept_c = in_valid && in_ready;

   // Single-cycle result and flags; SUB reuses the adder as a + ~b + 1.
   always_comb begin
      shamt_c = in_b[SHW-1:0];
      sum_c   = (in_op == OP_SUB) ? ({1'b0, in_a} + {1'b0, ~in_b} + W1'(1))
                                  : ({1'b0, in_a} + {1'b0, in_b});
      res_c   = '0;
      flags_c = '0;
      case (in_op)
         OP_AND:           res_c = in_a & in_b;
         OP_OR:            res_c = in_a | in_b;
         OP_XOR:           res_c = in_a ^ in_b;
         OP_NOR:           res_c = ~(in_a | in_b);
         OP_ADD: begin
            res_c            = sum_c[WIDTH-1:0];
            flags_c.carry    = sum_c[WIDTH];
            flags_c.overflow = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                               (sum_c[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_SUB: begin
            res_c            = sum_c[WIDTH-1:0];
            flags_c.carry    = sum_c[WIDTH];
            flags_c.overflow = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                               (sum_c[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_SLL, OP_SLLI:  res_c = in_a << shamt_c;
         OP_SRL, OP_SRLI:  res_c = in_a >> shamt_c;
         OP_SRA, OP_SRAI:  res_c = WIDTH'($signed(in_a) >>> shamt_c);
         OP_SLTU:          res_c = WIDTH'(in_a < in_b);
         OP_SLT:           res_c = WIDTH'($signed(in_a) < $signed(in_b));
         OP_DIVU:          res_c = '1;
         OP_MULLO:         res_c = '0;
         default:          res_c = '0;
      endcase
      flags_c.zero     = (res_c == '0);
      flags_c.negative = res_c[WIDTH-1];
   end

   always_comb begin
      iter_flags_c          = '0;
      iter_flags_c.zero     = (iter_result_c == '0);
      iter_flags_c.negative = iter_result_c[WIDTH-1];
   end

   // Next state; a zero in_b never enters ITER (DIVU by zero and MULLO by zero resolve at once).
   always_comb begin
      state_d       = state;
      start_c       = 1'b0;
      load_single_c = 1'b0;
      load_iter_c   = 1'b0;
      case (state)
         IDLE, HOLD: begin
            if ((state == HOLD) && out_ready) begin
               state_d = IDLE;
            end
            if (accept_c) begin
               if (((in_op == OP_MULLO) || (in_op == OP_DIVU)) && (in_b != '0)) begin
                  state_d = ITER;
                  start_c = 1'b1;
               end else begin
                  state_d       = HOLD;
                  load_single_c = 1'b1;
               end
            end
         end
         ITER: begin
            if (iter_done_c) begin
               state_d     = HOLD;
               load_iter_c = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result_q  <= '0;
         flags_q   <= '0;
      end else begin
         state     <= state_d;
         out_valid <= (state_d == HOLD);
         busy      <= (state_d == ITER);
         if (load_single_c) begin
            result_q <= res_c;
            flags_q  <= flags_c;
         end else if (load_iter_c) begin
            result_q <= iter_result_c;
            flags_q  <= iter_flags_c;
         end
      end
   end

   assign out_result   = result_q;
   assign out_carry    = flags_q.carry;
   assign out_zero     = flags_q.zero;
   assign out_negative = flags_q.negative;
   assign out_overflow = flags_q.overflow;

   alu_seq_iter #(
      .WIDTH(WIDTH)
   ) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_c),
      .op       (in_op),
      .a        (in_a),
      .b        (in_b),
      .done_c   (iter_done_c),
      .result_c (iter_result_c)
   );

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32) with an expected-result queue.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_carry;
   logic        out_zero;
   logic        out_negative;
   logic        out_overflow;
   logic        busy;

   typedef struct packed {
      logic [31:0] res;
      logic        c;
      logic        z;
      logic        n;
      logic        v;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_a         (in_a),
      .in_b         (in_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_carry    (out_carry),
      .out_zero     (out_zero),
      .out_negative (out_negative),
      .out_overflow (out_overflow),
      .busy         (busy)
   );

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [32:0] s;
      logic [63:0] p;
      longint      sa;
      longint      sbv;
      longint      d;
      logic [4:0]  sh;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      sh  = b[4:0];
      e   = '0;
      case (op)
         OP_AND:           e.res = a & b;
         OP_OR:            e.res = a | b;
         OP_XOR:           e.res = a ^ b;
         OP_NOR:           e.res = ~(a | b);
         OP_ADD: begin
            s     = {1'b0, a} + {1'b0, b};
            e.res = s[31:0];
            e.c   = s[32];
            d     = sa + sbv;
            e.v   = (d != longint'($signed(e.res)));
         end
         OP_SUB: begin
            e.res = a - b;
            e.c   = (a >= b);
            d     = sa - sbv;
            e.v   = (d != longint'($signed(e.res)));
         end
         OP_SLL, OP_SLLI:  e.res = a << sh;
         OP_SRL, OP_SRLI:  e.res = a >> sh;
         OP_SRA, OP_SRAI:  e.res = $unsigned($signed(a) >>> sh);
         OP_SLT:           e.res = (sa < sbv) ? 32'd1 : 32'd0;
         OP_SLTU:          e.res = (a < b) ? 32'd1 : 32'd0;
         OP_MULLO: begin
            p     = {32'd0, a} * {32'd0, b};
            e.res = p[31:0];
         end
         OP_DIVU:          e.res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default:          e.res = 32'd0;
      endcase
      e.z = (e.res == 32'd0);
      e.n = e.res[31];
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_front(input string tag);
      exp_t e;
      tests++;
      assert (sb.size() > 0) else begin
         fails++;
         $error("FAIL %s: result presented with no expectation queued", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, " result"}, out_result, e.res);
         check({tag, " flags"}, {28'd0, out_carry, out_zero, out_negative, out_overflow},
               {28'd0, e.c, e.z, e.n, e.v});
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      if (push) sb.push_back(model(op, a, b));
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_op    = 4'($urandom);
      in_a     = $urandom;
      in_b     = $urandom;
   endtask

   task automatic single_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
      drive(op, a, b, 1'b1);
      tick();
      idle_inputs();
      check({tag, " valid"}, 32'(out_valid), 32'd1);
      check_front(tag);
      tick();
      check({tag, " drained"}, 32'(out_valid), 32'd0);
   endtask

   task automatic multi_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      int n;
      bit ok;
      drive(op, a, b, 1'b1);
      tick();
      idle_inputs();
      n  = 1;
      ok = 1'b1;
      while (!out_valid && n < 60) begin
         if (busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
         tick();
         n++;
      end
      check({tag, " busy/in_ready while iterating"}, 32'(ok), 32'd1);
      check({tag, " latency"}, 32'(n), 32'd33);
      check({tag, " busy after done"}, 32'(busy), 32'd0);
      check_front(tag);
      tick();
   endtask

   initial begin
      bit stale;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 4'd0;
      in_a      = 32'd0;
      in_b      = 32'd0;
      out_ready = 1'b1;
      tick();
      tick();
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset result", out_result, 32'd0);
      check("reset flags", {28'd0, out_carry, out_zero, out_negative, out_overflow}, 32'd0);
      rst_n = 1'b1;
      check("in_ready after release", 32'(in_ready), 32'd1);

      single_op("ADD wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1);
      single_op("SUB ovf", OP_SUB, 32'h8000_0000, 32'h1);
      single_op("SLT", OP_SLT, 32'hFFFF_FFFF, 32'h1);
      single_op("SLTU", OP_SLTU, 32'hFFFF_FFFF, 32'h1);
      single_op("SLL upper ignored", OP_SLL, 32'h1, 32'h21);
      single_op("SRAI", OP_SRAI, 32'h8000_0000, 32'h3F);
      single_op("SRLI", OP_SRLI, 32'h8000_0000, 32'h4);
      single_op("NOR", OP_NOR, 32'h0, 32'h0);
      single_op("XOR", OP_XOR, 32'hA5A5_0F0F, 32'h5A5A_0F0F);
      single_op("DIVU by zero", OP_DIVU, 32'h1234, 32'h0);

      multi_op("MULLO", OP_MULLO, 32'h0001_0001, 32'h3);
      multi_op("DIVU", OP_DIVU, 32'd100, 32'd7);
      multi_op("MULLO max", OP_MULLO, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Backpressure: result must stay frozen while out_ready is low.
      drive(OP_SUB, 32'h5, 32'h9, 1'b1);
      out_ready = 1'b0;
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         check("stall valid", 32'(out_valid), 32'd1);
         check("stall result", out_result, sb[0].res);
         check("stall flags", {28'd0, out_carry, out_zero, out_negative, out_overflow},
               {28'd0, sb[0].c, sb[0].z, sb[0].n, sb[0].v});
         check("stall in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      check_front("stalled SUB");
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(OP_ADD, 32'(i) * 32'h1111_1111, 32'(i + 1), 1'b1);
         tick();
         check("b2b valid", 32'(out_valid), 32'd1);
         check_front("b2b ADD");
      end
      idle_inputs();
      tick();
      check("b2b drained", 32'(out_valid), 32'd0);

      // Reset mid-iteration must discard the operation.
      drive(OP_MULLO, 32'hDEAD_BEEF, 32'h0001_2345, 1'b0);
      tick();
      idle_inputs();
      repeat (9) tick();
      check("mid-op busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async reset out_valid", 32'(out_valid), 32'd0);
      check("async reset busy", 32'(busy), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      check("in_ready after mid-op reset", 32'(in_ready), 32'd1);
      stale = 1'b0;
      repeat (40) begin
         tick();
         if (out_valid) stale = 1'b1;
      end
      check("no stale result", 32'(stale), 32'd0);

      single_op("AND after reset", OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
      check("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: power of two, 8..64).
REQ-002 SHALL have derived localparam SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk input 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n input 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid input 1: operation presented.
REQ-006 SHALL have port in_ready output 1: operation accepted when in_valid && in_ready at a clk edge.
REQ-007 SHALL have port in_op input 4: operation code, see REQ-015.
REQ-008 SHALL have ports in_a and in_b, input WIDTH each: operands.
REQ-009 SHALL have port out_valid output 1: result held on outputs.
REQ-010 SHALL have port out_ready input 1: result consumed when out_valid && out_ready at a clk edge.
REQ-011 SHALL have port out_result output WIDTH: result.
REQ-012 SHALL have ports out_carry, out_zero, out_negative and out_overflow, output 1 each: flags.
REQ-013 SHALL have port busy output 1: high while a multi-cycle operation iterates.

Function
REQ-014 SHALL use states IDLE, ITER and HOLD: IDLE->ITER on accepting MULLO/DIVU with in_b!=0; ITER->HOLD when the iteration counter reaches WIDTH-1; any accept of a single-cycle op or DIVU with in_b==0 ->HOLD; HOLD->IDLE on consume; HOLD->HOLD or HOLD->ITER on consume with a simultaneous accept.
REQ-015 SHALL decode op codes: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 XOR, 5 SRA, 6 SUB, 7 SLTU, 8 SLT (signed), 9 SRL, 10 SLLI, 11 SRLI, 12 NOR (~(a|b)), 13 SRAI, 14 MULLO (low WIDTH bits of unsigned product), 15 DIVU (unsigned quotient).
REQ-016 SHALL shift by in_b[SHW-1:0] for all shift ops, ignoring upper bits; register and immediate variants behave identically.
REQ-017 SHALL produce SLT/SLTU results of exactly 1 or 0.
REQ-018 SHALL set out_carry to the carry-out of a+b for ADD and of a+~b+1 for SUB (1 means no borrow), and to 0 for all other ops.
REQ-019 SHALL set out_overflow to two's-complement overflow for ADD/SUB, and to 0 otherwise.
REQ-020 SHALL set out_zero = (out_result==0) and out_negative = out_result[WIDTH-1] for every op.
REQ-021 SHALL drive in_ready = (state==IDLE) || (state==HOLD && out_ready), combinationally.
REQ-022 SHALL assert out_valid on the edge after acceptance for single-cycle ops and DIVU by zero.
REQ-023 SHALL assert out_valid WIDTH+1 edges after acceptance for MULLO and DIVU (shift-add multiply, restoring divide, one bit per cycle).
REQ-024 SHALL return all-ones for DIVU with in_b==0, with out_zero=0 and out_negative=1.
REQ-025 SHALL hold out_result and all flags stable while out_valid && !out_ready.
REQ-026 SHALL sustain one single-cycle op per cycle while out_ready is held at 1.
REQ-027 SHALL keep busy high exactly while in ITER; in_ready SHALL be 0 throughout ITER.
REQ-028 SHALL accept no operation when in_valid is low, and SHALL ignore in_op/in_a/in_b when not accepted.

Reset
REQ-029 SHALL, while rst_n is low, drive out_valid=0, busy=0, out_result=0 and all flags 0, and force state to IDLE, regardless of clk.
REQ-030 SHALL discard any in-flight ITER operation when reset asserts mid-operation, producing no result after release.
REQ-031 SHALL present in_ready=1 on the first cycle after rst_n deasserts.

Structure
REQ-032 SHALL place the op-code constants and the state enum in shared package alu_seq_pkg.
REQ-033 SHALL implement the iterative multiply/divide datapath (accumulator, partial remainder, counter) in sub-module alu_seq_iter, with start/done handshake; single-cycle ops stay in alu_seq.

Verification (WIDTH=32)
REQ-034 SHALL cover: ADD 0xFFFFFFFF+0x1 -> result 0x0, carry=1, zero=1, overflow=0, out_valid 1 cycle after accept.
REQ-035 SHALL cover: SUB 0x80000000-0x1 -> 0x7FFFFFFF, overflow=1, carry=1; SLT 0xFFFFFFFF,0x1 -> 1; SLTU same operands -> 0.
REQ-036 SHALL cover: MULLO 0x00010001*0x00000003 -> 0x00030003 at 33 cycles, busy=1 and in_ready=0 throughout; DIVU 100/7 -> 14 at 33 cycles.
REQ-037 SHALL cover: DIVU 0x1234/0x0 -> 0xFFFFFFFF 1 cycle after accept, negative=1.
REQ-038 SHALL cover: hold out_ready=0 for 3 cycles with a result pending -> result/flags stable, in_ready=0; then 4 back-to-back ADDs with out_ready=1 -> 4 results on 4 consecutive cycles.
REQ-039 SHALL cover: rst_n low at cycle 10 of MULLO -> out_valid=0 immediately, in_ready=1 after release, no stale result ever presented.
